conv_acc_tx: RTL and testbench
==============================

Name: conv_acc_tx

Overview:
- Convolution accumulator that feeds the ReLU stage.
- Accepts a stream of pixel/weight taps per channel (R, G, B) and multiply-accumulates KSIZE*KSIZE taps into one window sum per channel.
- Emits three 32-bit signed Q.8 results with a one-cycle ack pulse: the transmitter side of the Conv_out/ack interface.
- Sits between the line-buffer/window fetch and ReLU.

Parameters:
- KSIZE, 3: kernel edge. Taps per window = KSIZE*KSIZE. Legal range 1..15; out-of-range is a fatal elaboration error.
- ACC_W, 40: internal accumulator width (signed).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous abort of the current window
- in_valid  in  1  tap present on pix_*/w_*
- in_ready  out  1  block can accept a tap this cycle
- pix_R, pix_G, pix_B  in  16 each  unsigned Q8.8 pixel
- w_R, w_G, w_B  in  16 each  signed Q8.8 weight
- Conv_out_R, Conv_out_G, Conv_out_B  out  32 each  signed window sum, Q.8
- ack  out  1  one-cycle pulse; Conv_out_* valid and held until next ack

Behaviour:
- Reset (rst_n=0, async): state IDLE, tap counter 0, accumulators 0, Conv_out_* = 0, ack = 0, in_ready = 0 while held. After release, in_ready = 1 from the first clock edge.
- Tap accepted when in_valid && in_ready on a rising clk.
- Product = $signed({1'b0,pix}) * $signed(w): 33-bit signed, sign-extended to ACC_W.
- FSM states:
  - IDLE: in_ready=1. An accepted tap loads acc = product (no stale add) and sets cnt=1. Go to ACC, or to EMIT directly if KSIZE==1.
  - ACC: in_ready=1. An accepted tap does acc += product, cnt++. When the accepted tap is tap KSIZE*KSIZE (cnt == taps-1 before increment), go to EMIT.
  - EMIT: in_ready=0. Conv_out_* <= acc[ACC_W-1-... ] as acc[39:8] (arithmetic, truncating toward -inf). ack=1 for exactly this cycle. Next state IDLE, cnt=0.
- Latency: ack asserts on the clock edge after the last tap is accepted. Conv_out_* and ack change together.
- Throughput: 1 window per taps+1 cycles. The bubble is the EMIT cycle.
- No overflow is possible for KSIZE≤15: |sum| < 2^23*225 < 2^31 after the shift. No saturation logic.
- Conv_out_* hold their value between acks. ack is never asserted two consecutive cycles.
- Gaps in in_valid are allowed anywhere; the counter holds across them.
- clr=1 in IDLE/ACC: next state IDLE, cnt=0, accumulator discarded, no ack, Conv_out_* unchanged. clr has priority over a tap presented in the same cycle; that tap is dropped, though in_ready remains 1.
- clr=1 in EMIT: ignored. The emit completes.
- rst_n low mid-window: everything returns to reset values immediately. No ack for the partial window.

Optional Feature:
- CONV_BIAS_EN defined:
  - Adds inputs bias_R/G/B (32-bit signed Q.8), sampled at the accepted first tap of each window.
  - EMIT outputs (acc>>>8)+bias, saturated to the signed 32-bit range (0x7FFFFFFF / 0x80000000).
- Not defined: no bias ports, no saturation logic. Output is exactly acc[39:8].

Decomposition:
- Package conv_pkg:
  - PIX_W=16, W_W=16, OUT_W=32, FRAC=8, ACC_W default
  - state enum {IDLE, ACC, EMIT}
  - function taps(KSIZE)
- Sub-module conv_mac_lane, one per channel (×3):
  - multiply, load/accumulate, shift-out
  - inputs: load, add, emit
- Shared FSM and counter in conv_acc_tx.

Test Plan:
- Unity window: KSIZE=3, 9 taps, all pix=0x0100, w=0x0100 on all channels, in_valid continuous. Expect ack 1 cycle after tap 9; Conv_out_*=0x00000900; in_ready=0 only in that cycle.
- Negative: same with w=0xFF00. Expect Conv_out_*=0xFFFFF700; ack single-cycle; next window starts cleanly (stale sum not added).
- Gapped stream + back-to-back: 9 taps with in_valid toggling 1,0,1,... then an immediate second window of pix=0x0200, w=0x0080. Expect first result 0x900; second 0x900; exactly two ack pulses; output held between them.
- Extreme: pix=0xFFFF, w=0x7FFF ×9. Expect Conv_out=0x047FF280; no wrap.
- clr after tap 5, then 9 fresh unity taps. Expect no ack for the aborted window; then a single ack with 0x900. Conv_out unchanged (previous value) until that ack.
- Async reset: assert rst_n=0 after tap 4 between clock edges. Expect outputs, ack, cnt = 0 immediately. After release, a full window gives the correct sum.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution accumulator (conv_acc_tx).
package conv_pkg;
    localparam int PIX_W     = 16;   // unsigned Q8.8 pixel
    localparam int W_W       = 16;   // signed Q8.8 weight
    localparam int OUT_W     = 32;   // signed Q.8 window sum
    localparam int FRAC      = 8;    // fractional bits dropped at emit
    localparam int ACC_W_DEF = 40;   // default accumulator width
    localparam int NUM_LANES = 3;    // R, G, B
    localparam int PROD_W    = PIX_W + W_W + 1;

    typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

    // Taps per window for a square kernel of edge k.
    function automatic int taps(input int k);
        return k * k;
    endfunction
endpackage

// File: rtl/conv_mac_lane.sv
// One channel of the window accumulator: multiply, load/accumulate, emit.
// The emitted value is taken from the post-update accumulator so the result
// lands on the same edge that accepts the last tap.
// With CONV_BIAS_EN defined, a per-window bias is added and the sum saturated.
module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             add,
    input  logic             emit,
    input  logic [PIX_W-1:0] pix,
    input  logic [W_W-1:0]   w,
`ifdef CONV_BIAS_EN
    input  logic [OUT_W-1:0] bias,
`endif
    output logic [OUT_W-1:0] conv_out
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic        [OUT_W-1:0]  result;

    assign prod     = $signed({1'b0, pix}) * $signed(w);
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    // First tap overwrites, so a previous or aborted window never leaks in.
    assign acc_next = load ? prod_ext : acc + prod_ext;

`ifdef CONV_BIAS_EN
    logic [OUT_W-1:0] bias_q;
    logic [OUT_W-1:0] bias_use;
    logic [OUT_W+1:0] sum;

    // Single-tap windows emit on the load edge, so use the live bias then.
    assign bias_use = load ? bias : bias_q;
    assign sum = {{2{acc_next[FRAC+OUT_W-1]}}, acc_next[FRAC +: OUT_W]}
               + {{2{bias_use[OUT_W-1]}}, bias_use};

    // Saturate when the top three bits disagree (value outside 32-bit range).
    always_comb begin
        result = sum[OUT_W-1:0];
        if (sum[OUT_W+1:OUT_W-1] != 3'b000 && sum[OUT_W+1:OUT_W-1] != 3'b111)
            result = sum[OUT_W+1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
    end

    // Capture the bias with the first tap of each window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    bias_q <= '0;
        else if (load) bias_q <= bias;
    end
`else
    // Arithmetic shift by FRAC, truncating toward -inf.
    assign result = acc_next[FRAC +: OUT_W];
`endif

    // Accumulator and held output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            conv_out <= '0;
        end else begin
            if (load || add) acc      <= acc_next;
            if (emit)        conv_out <= result;
        end
    end

endmodule

// File: rtl/conv_acc_tx.sv
// Convolution window accumulator feeding ReLU (Conv_out/ack transmitter).
// Shared FSM and tap counter drive three conv_mac_lane instances (R, G, B).
// Optional: define CONV_BIAS_EN for per-window bias with 32-bit saturation.
module conv_acc_tx
    import conv_pkg::*;
#(
    parameter int KSIZE = 3,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
`ifdef CONV_BIAS_EN
    input  logic [OUT_W-1:0] bias_R,
    input  logic [OUT_W-1:0] bias_G,
    input  logic [OUT_W-1:0] bias_B,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] pix_R,
    input  logic [PIX_W-1:0] pix_G,
    input  logic [PIX_W-1:0] pix_B,
    input  logic [W_W-1:0]   w_R,
    input  logic [W_W-1:0]   w_G,
    input  logic [W_W-1:0]   w_B,
    output logic [OUT_W-1:0] Conv_out_R,
    output logic [OUT_W-1:0] Conv_out_G,
    output logic [OUT_W-1:0] Conv_out_B,
    output logic             ack
);

    localparam int TAPS  = taps(KSIZE);
    localparam int CNT_W = $clog2(TAPS + 1);

    if (KSIZE < 1 || KSIZE > 15) begin : g_bad_ksize
        $fatal(1, "conv_acc_tx: KSIZE must be in 1..15");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last;
    logic             load;
    logic             add;

    // clr wins over a tap in the same cycle; in_ready is already 0 in EMIT.
    assign accept = in_valid && in_ready && !clr;
    assign last   = accept && ((state == IDLE) ? (TAPS == 1)
                                               : (cnt == CNT_W'(TAPS - 1)));
    assign load   = accept && (state == IDLE);
    assign add    = accept && (state == ACC);

    // Window FSM; in_ready and ack are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ack      <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            ack      <= 1'b0;
            in_ready <= 1'b1;
            case (state)
                IDLE: begin
                    if (clr) begin
                        cnt <= '0;
                    end else if (accept) begin
                        cnt <= CNT_W'(1);
                        if (last) begin
                            state    <= EMIT;
                            ack      <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (clr) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (accept) begin
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            state    <= EMIT;
                            ack      <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    logic [NUM_LANES-1:0][PIX_W-1:0] pix_a;
    logic [NUM_LANES-1:0][W_W-1:0]   w_a;
    logic [NUM_LANES-1:0][OUT_W-1:0] out_a;

    assign pix_a = {pix_B, pix_G, pix_R};
    assign w_a   = {w_B, w_G, w_R};
`ifdef CONV_BIAS_EN
    logic [NUM_LANES-1:0][OUT_W-1:0] bias_a;
    assign bias_a = {bias_B, bias_G, bias_R};
`endif

    for (genvar ln = 0; ln < NUM_LANES; ln++) begin : g_lane
        conv_mac_lane #(.ACC_W(ACC_W)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load),
            .add      (add),
            .emit     (last),
            .pix      (pix_a[ln]),
            .w        (w_a[ln]),
`ifdef CONV_BIAS_EN
            .bias     (bias_a[ln]),
`endif
            .conv_out (out_a[ln])
        );
    end

    assign Conv_out_R = out_a[0];
    assign Conv_out_G = out_a[1];
    assign Conv_out_B = out_a[2];

endmodule

// File: tb/tb_conv_acc_tx.sv
// Scoreboard bench for conv_acc_tx (KSIZE=3, default build).
module tb_conv_acc_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] pix_R = '0, pix_G = '0, pix_B = '0;
    logic [15:0] w_R = '0, w_G = '0, w_B = '0;
    logic [31:0] Conv_out_R, Conv_out_G, Conv_out_B;
    logic        ack;
`ifdef CONV_BIAS_EN
    logic [31:0] bias_R = '0, bias_G = '0, bias_B = '0;
`endif

    int checks = 0;
    int failures = 0;
    logic [95:0] exp_q[$];

    always #5 clk = ~clk;

    conv_acc_tx #(.KSIZE(3)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
`ifdef CONV_BIAS_EN
        .bias_R(bias_R), .bias_G(bias_G), .bias_B(bias_B),
`endif
        .in_valid(in_valid), .in_ready(in_ready),
        .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B),
        .w_R(w_R), .w_G(w_G), .w_B(w_B),
        .Conv_out_R(Conv_out_R), .Conv_out_G(Conv_out_G), .Conv_out_B(Conv_out_B),
        .ack(ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Present one tap; waits (bounded) for in_ready, returns 1 ns after acceptance.
    task automatic tap(input logic [15:0] pr, input logic [15:0] wr,
                       input logic [15:0] pg, input logic [15:0] wg,
                       input logic [15:0] pb, input logic [15:0] wb);
        int g = 0;
        @(negedge clk);
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) chk("tap_ready_timeout", 32'(in_ready), 32'd1);
        pix_R = pr; w_R = wr; pix_G = pg; w_G = wg; pix_B = pb; w_B = wb;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic window(input logic [15:0] p, input logic [15:0] w, input logic [31:0] exp);
        exp_q.push_back({exp, exp, exp});
        for (int i = 0; i < 9; i++) tap(p, w, p, w, p, w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops expected result on each ack, checks hold and handshake rules.
    initial begin
        logic [95:0] last_v = '0;
        logic [95:0] e;
        logic        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_v = '0;
                prev_ack = 1'b0;
            end else if (ack) begin
                if (prev_ack) chk("ack_double", 32'd1, 32'd0);
                chk("in_ready_in_emit", 32'(in_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_R", Conv_out_R, e[31:0]);
                    chk("out_G", Conv_out_G, e[63:32]);
                    chk("out_B", Conv_out_B, e[95:64]);
                end
                last_v = {Conv_out_B, Conv_out_G, Conv_out_R};
                prev_ack = 1'b1;
            end else begin
                if ({Conv_out_B, Conv_out_G, Conv_out_R} !== last_v) begin
                    checks++;
                    failures++;
                    $display("FAIL out_hold got=%h exp=%h",
                             {Conv_out_B, Conv_out_G, Conv_out_R}, last_v);
                end
                prev_ack = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while held.
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_out_R", Conv_out_R, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Unity window; ack and in_ready=0 right after last tap.
        window(16'h0100, 16'h0100, 32'h0000_0900);
        chk("unity_ack_lat", 32'(ack), 32'd1);
        chk("unity_ready_lo", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("unity_ack_drop", 32'(ack), 32'd0);
        chk("unity_ready_hi", 32'(in_ready), 32'd1);

        // Negative weights, back-to-back with previous.
        window(16'h0100, 16'hFF00, 32'hFFFF_F700);

        // Gapped first window, then immediate second window.
        exp_q.push_back({3{32'h0000_0900}});
        for (int i = 0; i < 9; i++) begin
            tap(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
            idle(1);
        end
        window(16'h0200, 16'h0080, 32'h0000_0900);

        // Distinct per-channel values.
        exp_q.push_back({32'h0000_0900, 32'hFFFF_F700, 32'h0000_0900});
        for (int i = 0; i < 9; i++)
            tap(16'h0100, 16'h0100, 16'h0100, 16'hFF00, 16'h0200, 16'h0080);

        // Extreme magnitude.
        window(16'hFFFF, 16'h7FFF, 32'h047F_F280);
        idle(2);

        // Abort after tap 5 with a tap presented alongside clr, then fresh window.
        for (int i = 0; i < 5; i++) tap(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        @(negedge clk);
        clr = 1'b1;
        in_valid = 1'b1;
        pix_R = 16'h7000; pix_G = 16'h7000; pix_B = 16'h7000;
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_ready", 32'(in_ready), 32'd1);
        chk("clr_held_R", Conv_out_R, 32'h047F_F280);
        window(16'h0100, 16'h0100, 32'h0000_0900);
        idle(2);

        // Async reset mid-window after tap 4.
        for (int i = 0; i < 4; i++) tap(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_R", Conv_out_R, 32'h0);
        chk("arst_out_B", Conv_out_B, 32'h0);
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_cnt", 32'(dut.cnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        window(16'h0100, 16'hFF00, 32'hFFFF_F700);

        // Drain scoreboard with a bounded wait.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        idle(3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
